spi_apb_xfer_sequencer: RTL
===========================

# spi_apb_xfer_sequencer

APB master that configures and drives the SPI APB slave interface on behalf of a simple byte-stream client. After a `cfg_start` request it programs CR1, CR2 and BR. It then turns each accepted transmit byte into the full APB sequence: write DR, poll SR until SPIF, read DR. The received byte is returned on `rx_data`. It sits between the system-side byte client and the SPI block's APB port, and is the only APB master on that port.

## Interface
- `CR1_INIT`, 8'h50, value written to CR1 (addr 3'b000) during configuration
- `CR2_INIT`, 8'h00, value written to CR2 (addr 3'b001)
- `BR_INIT`, 8'h11, value written to BR (addr 3'b010)
- `POLL_LIMIT`, 255, maximum SR reads per transfer before timeout (1..255)
- `SPIF_BIT`, 7, bit of SR (addr 3'b011) that flags transfer complete
- Clock and reset: one clock; reset is asynchronous and active-low.
- `PCLK` in 1: clock, all logic on rising edge
- `PRESETn` in 1: asynchronous active-low reset
- `cfg_start` in 1: request (re)configuration; sampled in IDLE only
- `xfer_valid` in 1: transmit byte offered
- `xfer_data` in 8: transmit byte
- `xfer_ready` out 1: byte accepted when `xfer_valid & xfer_ready` at an edge
- `rx_valid` out 1: one-cycle pulse, `rx_data` valid
- `rx_data` out 8: last received byte; holds until next `rx_valid`
- `cfg_done` out 1: configuration completed without error
- `busy` out 1: FSM not in IDLE
- `err` out 1: one-cycle pulse on PSLVERR or poll timeout
- `err_code` out 2: 00 none, 01 PSLVERR, 10 timeout; holds until next `err`
- `PSEL`, `PENABLE`, `PWRITE` out 1 each: APB master controls
- `PADDR` out 3: APB address
- `PWDATA` out 8: APB write data
- `PRDATA` in 8: APB read data
- `PREADY` in 1: APB ready
- `PSLVERR` in 1: APB error, sampled with PREADY

## Operation
- Reset values: every output 0; FSM in IDLE; poll counter 0.
- FSM states: IDLE, CFG0, CFG1, CFG2, WR_DR, POLL, RD_DR.
- Each non-IDLE state performs exactly one APB access in two phases:
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1, held until PREADY=1.
  - PADDR, PWRITE and PWDATA are stable from SETUP through completion.
- Transitions on the completing ACCESS edge:
  - From IDLE:
    - IDLE with `cfg_start`=1 goes to CFG0. `cfg_start` has priority over `xfer_valid`, and `cfg_done` clears on entry.
    - `xfer_ready` = IDLE & `cfg_done` & !`cfg_start`. On accept, latch `xfer_data` and go to WR_DR.
  - Configuration: CFG0 writes CR1_INIT at 0, then CFG1. CFG1 writes CR2_INIT at 1, then CFG2. CFG2 writes BR_INIT at 2, sets `cfg_done`, then IDLE.
  - WR_DR writes the latched byte to addr 5 and goes to POLL with poll counter cleared.
  - POLL reads SR at addr 3 and increments the counter:
    - PRDATA[SPIF_BIT]=1: go to RD_DR.
    - Otherwise, if counter = POLL_LIMIT: timeout (err_code 10), then IDLE.
    - Otherwise: re-enter POLL SETUP.
  - RD_DR reads addr 5, captures PRDATA into `rx_data`, pulses `rx_valid`, then IDLE.
- PSLVERR=1 on any completing access:
  - Pulse `err` with code 01 and go to IDLE.
  - If in CFG0–CFG2, `cfg_done` stays 0.
  - No `rx_valid` for an aborted transfer.
- `xfer_data` changes after acceptance are ignored.
- Asynchronous reset mid-access drops PSEL/PENABLE immediately and discards the latched byte and `cfg_done`.

## Timing
- All outputs are registered.
- Accept edge T:
  - WR_DR SETUP is in cycle T+1 and ACCESS in T+2.
  - With zero wait states, the write completes at the end of T+2.
- Back-to-back accesses: the next SETUP is in the cycle immediately after the completing ACCESS, with no idle cycle between accesses of one sequence.
- Each wait state (PREADY=0 in ACCESS) adds exactly one cycle.
- Zero-wait transfer whose first SR read shows SPIF: 6 APB cycles (WR, SR, DR), `rx_valid` in cycle T+7.
- Configuration from `cfg_start` edge C: writes complete at the ends of C+2, C+4 and C+6; `cfg_done`=1 in C+7.
- `busy` rises the cycle after accept/start and falls in the cycle `rx_valid`, `cfg_done` or `err` is asserted.
- `xfer_ready` is low from the accept edge until back in IDLE.

## Test plan
- Reset, then `cfg_start` pulse with zero-wait slave -> writes (0,50),(1,00),(2,11) on consecutive 2-cycle accesses; `cfg_done`=1 at C+7; PSEL low afterwards.
- Send `xfer_data`=A9; SR returns SPIF only on 3rd read; DR read returns 55 -> one DR write of A9, exactly 3 SR reads, one DR read; `rx_valid` pulse with `rx_data`=55.
- Same transfer with PREADY held low 2 cycles on every ACCESS -> identical address/data sequence, each access 4 cycles, PADDR/PWDATA stable throughout.
- PSLVERR=1 on the CR2 write -> `err` pulse with code 01, no BR write, `cfg_done`=0, `xfer_ready`=0.
- POLL_LIMIT=4 with SPIF never set -> exactly 4 SR reads, `err` code 10, no DR read, return to IDLE with `xfer_ready`=1.
- PRESETn low during POLL ACCESS -> PSEL/PENABLE drop asynchronously; all outputs 0; new `xfer_valid` is ignored until `cfg_start` completes.

Source files
------------

// File: rtl/spi_apb_xfer_sequencer.sv
// APB master that configures the SPI APB slave (CR1/CR2/BR) and then runs each client
// byte as write DR -> poll SR for SPIF -> read DR, returning the received byte.
module spi_apb_xfer_sequencer #(
    parameter logic [7:0] CR1_INIT   = 8'h50,
    parameter logic [7:0] CR2_INIT   = 8'h00,
    parameter logic [7:0] BR_INIT    = 8'h11,
    parameter int         POLL_LIMIT = 255,
    parameter int         SPIF_BIT   = 7
) (
    input  logic       PCLK,
    input  logic       PRESETn,
    input  logic       cfg_start,
    input  logic       xfer_valid,
    input  logic [7:0] xfer_data,
    output logic       xfer_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       cfg_done,
    output logic       busy,
    output logic       err,
    output logic [1:0] err_code,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [2:0] PADDR,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR
);

    typedef enum logic [2:0] {IDLE, CFG0, CFG1, CFG2, WR_DR, POLL, RD_DR} state_t;

    localparam logic [2:0] ADDR_CR1 = 3'd0;
    localparam logic [2:0] ADDR_CR2 = 3'd1;
    localparam logic [2:0] ADDR_BR  = 3'd2;
    localparam logic [2:0] ADDR_SR  = 3'd3;
    localparam logic [2:0] ADDR_DR  = 3'd5;

    state_t     state_q, state_d;
    logic [7:0] poll_cnt_q, poll_cnt_d;
    logic       cfg_done_q, cfg_done_d;
    logic       xfer_ready_q;
    logic       rx_valid_q, err_q, busy_q;
    logic [7:0] rx_data_q;
    logic [1:0] err_code_q;
    logic       psel_q, penable_q, pwrite_q;
    logic [2:0] paddr_q;
    logic [7:0] pwdata_q;

    logic       launch, abort, timeout, rx_fire, access_done;
    logic [2:0] setup_addr;
    logic       setup_write;
    logic [7:0] setup_wdata;

    always_comb begin
        state_d     = state_q;
        poll_cnt_d  = poll_cnt_q;
        cfg_done_d  = cfg_done_q;
        launch      = 1'b0;
        abort       = 1'b0;
        timeout     = 1'b0;
        rx_fire     = 1'b0;
        access_done = psel_q && penable_q && PREADY;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    state_d    = CFG0;
                    cfg_done_d = 1'b0;
                    launch     = 1'b1;
                end else if (xfer_valid && xfer_ready) begin
                    state_d = WR_DR;
                    launch  = 1'b1;
                end
            end
            default: begin
                if (access_done) begin
                    if (PSLVERR) begin
                        state_d = IDLE;
                        abort   = 1'b1;
                    end else begin
                        case (state_q)
                            CFG0: begin
                                state_d = CFG1;
                                launch  = 1'b1;
                            end
                            CFG1: begin
                                state_d = CFG2;
                                launch  = 1'b1;
                            end
                            CFG2: begin
                                state_d    = IDLE;
                                cfg_done_d = 1'b1;
                            end
                            WR_DR: begin
                                state_d    = POLL;
                                poll_cnt_d = 8'd0;
                                launch     = 1'b1;
                            end
                            POLL: begin
                                poll_cnt_d = poll_cnt_q + 8'd1;
                                if (PRDATA[SPIF_BIT]) begin
                                    state_d = RD_DR;
                                    launch  = 1'b1;
                                end else if (poll_cnt_d == 8'(POLL_LIMIT)) begin
                                    state_d = IDLE;
                                    timeout = 1'b1;
                                end else begin
                                    launch = 1'b1;
                                end
                            end
                            RD_DR: begin
                                state_d = IDLE;
                                rx_fire = 1'b1;
                            end
                            default: state_d = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    // APB fields for the access that starts in the state being entered
    always_comb begin
        setup_addr  = 3'd0;
        setup_write = 1'b0;
        setup_wdata = 8'h00;
        case (state_d)
            CFG0:  begin setup_addr = ADDR_CR1; setup_write = 1'b1; setup_wdata = CR1_INIT;  end
            CFG1:  begin setup_addr = ADDR_CR2; setup_write = 1'b1; setup_wdata = CR2_INIT;  end
            CFG2:  begin setup_addr = ADDR_BR;  setup_write = 1'b1; setup_wdata = BR_INIT;   end
            WR_DR: begin setup_addr = ADDR_DR;  setup_write = 1'b1; setup_wdata = xfer_data; end
            POLL:  begin setup_addr = ADDR_SR;  setup_write = 1'b0; end
            RD_DR: begin setup_addr = ADDR_DR;  setup_write = 1'b0; end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            poll_cnt_q   <= 8'd0;
            cfg_done_q   <= 1'b0;
            xfer_ready_q <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= 8'h00;
            err_q        <= 1'b0;
            err_code_q   <= 2'b00;
            busy_q       <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= 3'd0;
            pwdata_q     <= 8'h00;
        end else begin
            state_q      <= state_d;
            poll_cnt_q   <= poll_cnt_d;
            cfg_done_q   <= cfg_done_d;
            xfer_ready_q <= (state_d == IDLE) && cfg_done_d;
            busy_q       <= (state_d != IDLE);
            rx_valid_q   <= rx_fire;
            err_q        <= abort || timeout;
            if (rx_fire)
                rx_data_q <= PRDATA;
            if (abort)
                err_code_q <= 2'b01;
            else if (timeout)
                err_code_q <= 2'b10;
            // PWDATA doubles as the latched transmit byte for the whole DR write
            if (launch) begin
                psel_q    <= 1'b1;
                penable_q <= 1'b0;
                paddr_q   <= setup_addr;
                pwrite_q  <= setup_write;
                pwdata_q  <= setup_wdata;
            end else if (psel_q && !penable_q) begin
                penable_q <= 1'b1;
            end else if (access_done) begin
                psel_q    <= 1'b0;
                penable_q <= 1'b0;
            end
        end
    end

    // cfg_start takes priority over a waiting byte on the very same edge
    assign xfer_ready = xfer_ready_q && !cfg_start;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign cfg_done   = cfg_done_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;

endmodule
